// File: rtl/mul_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the multiply sequencer, the hazard unit and the
// testbench.
//   mul_state_t : sequencer FSM state encoding (IDLE, RUN, DONE)
//   MUL_DATA_W  : default operand width of the core
//   MUL_LAT     : issue-to-result latency in cycles at the default width
//   mul_lat()   : the same latency for any other operand width
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_DATA_W = 64;

    // One launch cycle plus one shift-add step per operand bit.
    localparam int MUL_LAT = MUL_DATA_W + 1;

    function automatic int mul_lat(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl_if
// EX-stage to multiply-sequencer bundle.
//   master (EX stage)  : drives enable, start, flush, op_a, op_b;
//                        receives stall, done, result
//   slave (sequencer)  : the mirror image
// -----------------------------------------------------------------------------
interface mul_seq_ctrl_if #(
    parameter int DATA_W = 64
);

    logic              enable;
    logic              start;
    logic              flush;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              stall;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (
        output enable, start, flush, op_a, op_b,
        input  stall, done, result
    );

    modport slave (
        input  enable, start, flush, op_a, op_b,
        output stall, done, result
    );

endinterface

// File: rtl/mul_seq_ctrl_dp.sv
// -----------------------------------------------------------------------------
// mul_shift_add_dp
// Radix-2 shift-add datapath: multiplicand, multiplier and accumulator
// registers plus the adder.
//   clk, arst_n : clock and asynchronous active-low reset
//   load        : capture op_a/op_b and clear the accumulator
//   step        : perform one shift-add iteration
//   op_a, op_b  : operands, sampled only when load is high
//   acc         : accumulator value including the partial product of the
//                 current step, so the controller can capture the final
//                 product on the same edge as the last step
// -----------------------------------------------------------------------------
module mul_shift_add_dp #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] acc
);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplr;
    logic [DATA_W-1:0] acc_q;

    // Look-ahead sum; the add wraps naturally at DATA_W bits, which is
    // exactly the low half of the product.
    assign acc = acc_q + (mplr[0] ? mcand : '0);

    // Registers only move on load or step, so holding both low freezes the
    // datapath (used for enable low and for the idle/done states).
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mcand <= '0;
            mplr  <= '0;
            acc_q <= '0;
        end else if (load) begin
            mcand <= op_a;
            mplr  <= op_b;
            acc_q <= '0;
        end else if (step) begin
            acc_q <= acc;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl
// Multi-cycle multiply sequencer beside the EX-stage ALU. Runs DATA_W
// shift-add steps and stalls the front of the pipeline until the low DATA_W
// bits of op_a*op_b are available.
//   clk, arst_n : clock and asynchronous active-low reset
//   bus (slave) : enable, start, flush, op_a, op_b in;
//                 stall (combinational), done and result (registered) out
// -----------------------------------------------------------------------------
module mul_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic           clk,
    input  logic           arst_n,
    mul_seq_ctrl_if.slave  bus
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    mul_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              done_q;
    logic [DATA_W-1:0] result_q;
    logic              launch;
    logic              step;
    logic [DATA_W-1:0] acc;

    // Flush squashes both a launch and any further iteration; enable low
    // blocks every datapath update.
    assign launch = bus.enable && (state == IDLE) && bus.start && !bus.flush;
    assign step   = bus.enable && (state == RUN) && !bus.flush;

    // Stall covers the launch cycle and every RUN cycle but drops in DONE so
    // the MUL leaves EX on the DONE edge. Forced low during reset.
    assign bus.stall = arst_n && bus.enable &&
                       (((state == IDLE) && bus.start && !bus.flush) ||
                        (state == RUN));

    assign bus.done   = done_q;
    assign bus.result = result_q;

    mul_shift_add_dp #(
        .DATA_W (DATA_W)
    ) u_dp (
        .clk    (clk),
        .arst_n (arst_n),
        .load   (launch),
        .step   (step),
        .op_a   (bus.op_a),
        .op_b   (bus.op_b),
        .acc    (acc)
    );

    // Sequencer FSM with step counter and registered outputs. The final
    // result is taken from the datapath look-ahead so it includes the last
    // step's add. done is a one-cycle pulse covering the DONE state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (bus.enable) begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state <= RUN;
                            cnt   <= '0;
                        end
                    end
                    RUN: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            result_q <= acc;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
